// File: rtl/mul_pkg.sv
// Shared types and constants for the Booth radix-4 sequential multiplier.
package mul_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int ITER      = DEF_WIDTH / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_PM   = 3'd1,
    OP_P2M  = 3'd2,
    OP_NM   = 3'd3,
    OP_N2M  = 3'd4
  } booth_op_e;

  function automatic int iter_of(input int w);
    return w / 2;
  endfunction
endpackage

// File: rtl/booth_bitpair_recoder.sv
// Radix-4 Booth recoder: maps the window {q[i+1], q[i], q[i-1]} to an add/sub op.
module booth_bitpair_recoder
  import mul_pkg::*;
(
  input  logic [2:0] win_i,
  output booth_op_e  op_o
);
  always_comb begin
    op_o = OP_ZERO;
    unique case (win_i)
      3'b001, 3'b010: op_o = OP_PM;
      3'b011:         op_o = OP_P2M;
      3'b100:         op_o = OP_N2M;
      3'b101, 3'b110: op_o = OP_NM;
      default:        op_o = OP_ZERO;
    endcase
  end
endmodule

// File: rtl/booth_mul_32_bit.sv
// Sequential signed multiplier, WIDTH x WIDTH -> 2*WIDTH, two multiplier bits per clock.
module booth_mul_32_bit
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int AW    = WIDTH + 2;
  localparam int ITERS = iter_of(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d, mx_q, mx_d;
  logic [WIDTH-1:0] qr_q, qr_d, hi_q, hi_d, lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  booth_op_e        op;
  logic [AW-1:0]    term, sum;

  booth_bitpair_recoder u_rec (
    .win_i ({qr_q[1:0], qm1_q}),
    .op_o  (op)
  );

  // Two guard bits in A keep +/-2M exact even for the most negative multiplicand.
  always_comb begin
    term = '0;
    unique case (op)
      OP_PM:   term = mx_q;
      OP_P2M:  term = mx_q << 1;
      OP_NM:   term = -mx_q;
      OP_N2M:  term = -(mx_q << 1);
      default: term = '0;
    endcase
    sum = a_q + term;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mx_d    = mx_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          mx_d    = {{2{multiplicand[WIDTH-1]}}, multiplicand};
          qr_d    = multiplier;
          qm1_d   = 1'b0;
          cnt_d   = CW'(ITERS);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        qr_d  = {sum[1:0], qr_q[WIDTH-1:2]};
        qm1_d = qr_q[1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          hi_d    = a_d[WIDTH-1:0];
          lo_d    = qr_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      mx_q    <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mx_q    <= mx_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
